// File: rtl/mau_pkg.sv
// mau_pkg: shared types and helpers for the memory access unit.
//   mau_state_e    : control states (IDLE, RD, WR, RESP)
//   mau_req_t      : request fields captured at acceptance
//   MAU_SIZE_*     : Req_Size encodings (2'b11 is illegal)
//   mau_align_err(): size/alignment error check (range check lives in the top)
package mau_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} mau_state_e;

  localparam logic [1:0] MAU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MAU_SIZE_HALF = 2'b01;
  localparam logic [1:0] MAU_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
  } mau_req_t;

  // Illegal size, odd halfword, or word not on a 4-byte boundary.
  function automatic logic mau_align_err(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) ||
           ((size == MAU_SIZE_HALF) && lo[0]) ||
           ((size == MAU_SIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational little-endian lane steering.
//   word       in  32  word read from memory
//   addr_lo    in  2   byte offset within the word
//   size       in  2   byte / half / word
//   sign_ext   in  1   sign-extend sub-word loads
//   wdata      in  32  right-aligned store data
//   load_data  out 32  addressed lane shifted to bit 0 and extended
//   store_word out 32  word with only the addressed lane(s) replaced by wdata
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] mask;

  always_comb begin
    // Halfwords ignore addr_lo[0]; alignment is already guaranteed upstream.
    sh         = (size == MAU_SIZE_HALF) ? {addr_lo[1], 4'b0000} : {addr_lo, 3'b000};
    lane       = 16'(word >> sh);
    mask       = 32'h0;
    load_data  = word;
    store_word = wdata;
    case (size)
      MAU_SIZE_BYTE: begin
        load_data  = {{24{sign_ext & lane[7]}}, lane[7:0]};
        mask       = 32'h0000_00FF << sh;
        store_word = (word & ~mask) | ({24'h0, wdata[7:0]} << sh);
      end
      MAU_SIZE_HALF: begin
        load_data  = {{16{sign_ext & lane[15]}}, lane};
        mask       = 32'h0000_FFFF << sh;
        store_word = (word & ~mask) | ({16'h0, wdata[15:0]} << sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit driving a word memory.
// Byte/half stores are read-modify-write; sub-word loads are extended.
// Misaligned, illegal-size and out-of-range requests complete with Resp_Err
// one cycle after acceptance without any memory strobe.
//   Req_*   : valid/ready request (Write, Size, Signed, Addr, Wdata)
//   Resp_*  : one-cycle completion pulse with Rdata / Err
//   Mem_*   : Address (word aligned), Write_data, Read/Write strobes, Read_Data
// Optional build macro MAU_STATS_EN adds saturating 16-bit Load_Count,
// Store_Count and Err_Count outputs.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Size,
  input  logic        Req_Signed,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_Wdata,
  output logic        Resp_Valid,
  output logic [31:0] Resp_Rdata,
  output logic        Resp_Err,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_Write_data,
  output logic        Mem_Read,
  output logic        Mem_Write,
`ifdef MAU_STATS_EN
  output logic [15:0] Load_Count,
  output logic [15:0] Store_Count,
  output logic [15:0] Err_Count,
`endif
  input  logic [31:0] Mem_Read_Data
);

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  mau_state_e       state, state_nxt;
  mau_req_t         req_q;
  logic [LAT_W-1:0] lat_cnt;
  logic             req_err, lat_done;
  logic [31:0]      load_data, store_word;

  assign req_err  = mau_align_err(Req_Size, Req_Addr[1:0]) ||
                    (Req_Addr[31:2] >= 30'(MEM_WORDS));
  assign lat_done = (lat_cnt == LAT_W'(MEM_LAT - 1));

  mau_lane_align u_align (
    .word      (Mem_Read_Data),
    .addr_lo   (req_q.addr_lo),
    .size      (req_q.size),
    .sign_ext  (req_q.sign_ext),
    .wdata     (req_q.wdata),
    .load_data (load_data),
    .store_word(store_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    state_nxt  = state;
    Req_Ready  = 1'b0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    Resp_Valid = 1'b0;
    case (state)
      IDLE: begin
        Req_Ready = 1'b1;
        if (Req_Valid) begin
          if (req_err)                                      state_nxt = RESP;
          else if (Req_Write && (Req_Size == MAU_SIZE_WORD)) state_nxt = WR;
          else                                              state_nxt = RD;
        end
      end
      RD: begin
        Mem_Read = 1'b1;
        if (lat_done) state_nxt = req_q.write ? WR : RESP;
      end
      WR: begin
        Mem_Write = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        Resp_Valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q          <= '0;
      lat_cnt        <= '0;
      Mem_Address    <= '0;
      Mem_Write_data <= '0;
      Resp_Rdata     <= '0;
      Resp_Err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Req_Valid) begin
          req_q   <= '{write: Req_Write, size: Req_Size, sign_ext: Req_Signed,
                       addr_lo: Req_Addr[1:0], wdata: Req_Wdata};
          lat_cnt <= '0;
          if (req_err) begin
            Resp_Err <= 1'b1;
          end else begin
            Mem_Address    <= {Req_Addr[31:2], 2'b00};
            // Word stores go straight to WR; RMW stores overwrite this in RD.
            Mem_Write_data <= Req_Wdata;
          end
        end
        RD: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_done) begin
            if (req_q.write) Mem_Write_data <= store_word;
            else             Resp_Rdata     <= load_data;
          end
        end
        RESP: begin
          Resp_Rdata <= '0;
          Resp_Err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MAU_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Load_Count  <= '0;
      Store_Count <= '0;
      Err_Count   <= '0;
    end else if (state == RESP) begin
      if (Resp_Err) begin
        if (Err_Count != 16'hFFFF) Err_Count <= Err_Count + 16'd1;
      end else if (req_q.write) begin
        if (Store_Count != 16'hFFFF) Store_Count <= Store_Count + 16'd1;
      end else begin
        if (Load_Count != 16'hFFFF) Load_Count <= Load_Count + 16'd1;
      end
    end
  end
`endif

endmodule
